// File: rtl/barrel_shifter_32_pkg.sv
// Shared definitions for the ALU shift unit: widths, direction codes, opcodes.
package barrel_shifter_32_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int SHAMT_W_DEF = 5;

    // Direction encoding of the dir port
    localparam logic SHIFT_LEFT  = 1'b0;
    localparam logic SHIFT_RIGHT = 1'b1;

    // ALU opcodes that the ALU decodes into dir/arith for this unit
    typedef enum logic [1:0] {
        ALU_SHIFTL       = 2'd0,
        ALU_SHIFTR       = 2'd1,
        ALU_SHIFTR_ARITH = 2'd2
    } alu_shift_op_e;

endpackage

// File: rtl/barrel_shifter_32_stage.sv
// One log-shifter stage: right shift by DIST with fill bits when enabled.
module barrel_shift_stage #(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             en_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] data_o
);

    // Shift or pass through; the vacated top bits take the fill value
    assign data_o = en_i ? {{DIST{fill_i}}, data_i[WIDTH-1:DIST]} : data_i;

endmodule

// File: rtl/barrel_shifter_32.sv
// Registered 32-bit barrel shifter (SLL/SRL/SRA). A right-shift-only log
// core handles left shifts by bit-reversing the operand and the result.
module barrel_shifter_32
    import barrel_shifter_32_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in,
    input  logic [SHAMT_W-1:0] n,
    input  logic               dir,
    input  logic               arith,
    input  logic               in_valid,
    output logic [WIDTH-1:0]   out,
    output logic               out_valid
);

    logic [WIDTH-1:0] in_rev;
    logic [WIDTH-1:0] res_rev;
    logic [WIDTH-1:0] core_in;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] out_q;
    logic             out_valid_q;
    logic             fill;
    logic [SHAMT_W:0][WIDTH-1:0] stg;

    // Sign fill only for arithmetic right shifts; left shifts always zero-fill
    assign fill = arith & (dir == SHIFT_RIGHT) & in[WIDTH-1];

    // Bit-reverse wiring around the core for left shifts
    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign in_rev[i]  = in[WIDTH-1-i];
        assign res_rev[i] = stg[SHAMT_W][WIDTH-1-i];
    end

    assign core_in = (dir == SHIFT_RIGHT) ? in : in_rev;
    assign stg[0]  = core_in;

    // Stage k shifts by 2^k, LSB first
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        barrel_shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .data_i (stg[k]),
            .en_i   (n[k]),
            .fill_i (fill),
            .data_o (stg[k+1])
        );
    end

    assign res_d = (dir == SHIFT_RIGHT) ? stg[SHAMT_W] : res_rev;

    // Output register: load on valid operands, otherwise hold the last result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) out_q <= res_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_barrel_shifter_32.sv
// Self-checking bench for barrel_shifter_32: directed cases plus random
// operands compared against SV shift operators one cycle later.
module tb_barrel_shifter_32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in;
    logic [4:0]  n;
    logic        dir;
    logic        arith;
    logic        in_valid;
    logic [31:0] out;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    barrel_shifter_32 dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .n         (n),
        .dir       (dir),
        .arith     (arith),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input int s,
                                              input logic d, input logic ar);
        logic signed [31:0] sa;
        sa = a;
        if (!d)      return a << s;
        else if (ar) return sa >>> s;
        else         return a >> s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one operand set at the falling edge
    task automatic drive(input logic [31:0] a, input logic [4:0] s, input logic d,
                         input logic ar, input logic v);
        @(negedge clk);
        in = a; n = s; dir = d; arith = ar; in_valid = v;
    endtask

    // Sample just after the next rising edge
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_chk(input string tag, input logic [31:0] a, input logic [4:0] s,
                             input logic d, input logic ar, input logic [31:0] exp);
        drive(a, s, d, ar, 1'b1);
        settle();
        check(tag, out, exp);
        check({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        logic [4:0]  s;
        logic        d, ar;

        rst = 1'b1; in = '0; n = '0; dir = 1'b0; arith = 1'b0; in_valid = 1'b0;
        #1;
        check("reset_out", out, 32'h0);
        check("reset_vld", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Load a value then hit reset mid-cycle
        shift_chk("preload", 32'h12345678, 5'd0, 1'b0, 1'b0, 32'h12345678);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out", out, 32'h0);
        check("async_rst_vld", {31'b0, out_valid}, 32'd0);
        // Operands valid while reset is high at the edge produce nothing
        drive(32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1);
        settle();
        check("rst_edge_out", out, 32'h0);
        check("rst_edge_vld", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        shift_chk("post_rst", 32'h00000001, 5'd0, 1'b0, 1'b0, 32'h00000001);

        // Directed cases
        shift_chk("sll31_arith_ign", 32'h00000001, 5'd31, 1'b0, 1'b1, 32'h80000000);
        shift_chk("srl4",   32'h80000000, 5'd4,  1'b1, 1'b0, 32'h08000000);
        shift_chk("srl8",   32'hF0F0F0F0, 5'd8,  1'b1, 1'b0, 32'h00F0F0F0);
        shift_chk("sra4",   32'h80000000, 5'd4,  1'b1, 1'b1, 32'hF8000000);
        shift_chk("sra31n", 32'hFFFFFFFF, 5'd31, 1'b1, 1'b1, 32'hFFFFFFFF);
        shift_chk("sra31p", 32'h7FFFFFFF, 5'd31, 1'b1, 1'b1, 32'h00000000);
        shift_chk("srl31",  32'h80000000, 5'd31, 1'b1, 1'b0, 32'h00000001);
        shift_chk("sra0",   32'h8000A5A5, 5'd0,  1'b1, 1'b1, 32'h8000A5A5);

        // Back-to-back then hold
        drive(32'h0000000F, 5'd1, 1'b0, 1'b0, 1'b1);
        settle();
        check("b2b_l", out, 32'h0000001E);
        drive(32'h0000000F, 5'd1, 1'b1, 1'b0, 1'b1);
        settle();
        check("b2b_r", out, 32'h00000007);
        check("b2b_r_vld", {31'b0, out_valid}, 32'd1);
        drive(32'hFFFFFFFF, 5'bxxxxx, 1'bx, 1'bx, 1'b0);
        settle();
        check("hold_out", out, 32'h00000007);
        check("hold_vld", {31'b0, out_valid}, 32'd0);
        settle();
        check("hold_out2", out, 32'h00000007);

        // Every shift amount in each of the three modes
        for (int m = 0; m < 3; m++) begin
            for (int k = 0; k < 32; k++) begin
                a  = $urandom;
                d  = (m != 0);
                ar = (m == 2);
                drive(a, k[4:0], d, ar, 1'b1);
                settle();
                check($sformatf("sweep_m%0d_n%0d", m, k), out, ref_shift(a, k, d, ar));
            end
        end

        // Random operands, valid mostly high; holds checked when low
        begin
            logic [31:0] last;
            logic        v;
            last = out;
            for (int i = 0; i < 10000; i++) begin
                a  = $urandom;
                s  = 5'($urandom_range(0, 31));
                d  = 1'($urandom);
                ar = 1'($urandom);
                v  = ($urandom_range(0, 7) != 0);
                drive(a, s, d, ar, v);
                if (v) last = ref_shift(a, int'(s), d, ar);
                settle();
                check("rand_out", out, last);
                check("rand_vld", {31'b0, out_valid}, {31'b0, v});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
